// File: rtl/seq_prog_ctrl_if.sv
// Load/start/issue bundle between the board-level controls and the program sequencer.
// The master side drives the load/run controls; the slave side issues instructions to seq.
interface seq_prog_ctrl_if #(
  parameter int INST_W   = 8,
  parameter int DEPTH_LG = 4
);
  logic                i_load_we;
  logic [DEPTH_LG-1:0] i_load_addr;
  logic [INST_W-1:0]   i_load_data;
  logic [DEPTH_LG:0]   i_len;
  logic                i_start;
  logic                i_abort;
  logic                i_tx_busy;
  logic [INST_W-1:0]   o_inst;
  logic                o_inst_valid;
  logic [DEPTH_LG-1:0] o_pc;
  logic                o_busy;
  logic                o_done;

  modport master (
    output i_load_we, i_load_addr, i_load_data, i_len, i_start, i_abort, i_tx_busy,
    input  o_inst, o_inst_valid, o_pc, o_busy, o_done
  );

  modport slave (
    input  i_load_we, i_load_addr, i_load_data, i_len, i_start, i_abort, i_tx_busy,
    output o_inst, o_inst_valid, o_pc, o_busy, o_done
  );
endinterface

// File: rtl/seq_prog_ctrl.sv
// Program sequencer: loads a small instruction RAM, then issues it to seq with ALU hazard gaps
// and UART-busy stalls on SEND. Define SEQ_PROG_STEP_EN to add single-step control via i_step.
module seq_prog_ctrl #(
  parameter int INST_W   = 8,
  parameter int DEPTH_LG = 4,
  parameter int GAP      = 1,
  parameter int GUARD    = 4
) (
  input  logic clk,
  input  logic rst,
`ifdef SEQ_PROG_STEP_EN
  input  logic i_step,
`endif
  seq_prog_ctrl_if.slave bus
);
  localparam int DEPTH   = 1 << DEPTH_LG;
  localparam int CNT_MAX = (GAP > GUARD) ? GAP : GUARD;
  localparam int CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
  localparam logic [1:0] OP_SEND = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_GAP,
    S_TXWAIT,
    S_NEXT,
    S_DONE
`ifdef SEQ_PROG_STEP_EN
    , S_STEP
`endif
  } state_t;

`ifdef SEQ_PROG_STEP_EN
  localparam state_t S_POST = S_STEP;
`else
  localparam state_t S_POST = S_NEXT;
`endif

  logic [INST_W-1:0]   r_ram [DEPTH];
  state_t              r_state;
  logic [DEPTH_LG-1:0] r_pc;
  logic [DEPTH_LG:0]   r_len;
  logic [INST_W-1:0]   r_inst;
  logic                r_valid;
  logic                r_busy;
  logic                r_done;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_seen;

  logic w_idle;
  logic w_load_ok;
  logic w_is_send;
  logic w_last;
  logic w_step_rise;

  assign w_idle    = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_load_ok = bus.i_load_we && w_idle;
  assign w_is_send = (r_inst[INST_W-1 -: 2] == OP_SEND);
  assign w_last    = ({1'b0, r_pc} == (r_len - 1'b1));

`ifdef SEQ_PROG_STEP_EN
  logic r_step_d;
  assign w_step_rise = i_step && !r_step_d;

  always_ff @(posedge clk) begin
    if (rst) r_step_d <= 1'b0;
    else     r_step_d <= i_step;
  end
`else
  assign w_step_rise = 1'b0;
`endif

  // Writes only land while stopped, so a FETCH never races a write to the same word.
  always_ff @(posedge clk) begin
    if (w_load_ok) r_ram[bus.i_load_addr] <= bus.i_load_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_len   <= '0;
      r_inst  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
      r_seen  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (bus.i_abort) begin
        r_state <= S_IDLE;
        r_pc    <= '0;
        r_busy  <= 1'b0;
        r_done  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE, S_DONE: begin
            if (bus.i_start) begin
              r_pc  <= '0;
              r_len <= bus.i_len;
              if (bus.i_len == '0) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_state <= S_FETCH;
                r_done  <= 1'b0;
                r_busy  <= 1'b1;
              end
            end
          end
          S_FETCH: begin
            r_inst  <= r_ram[r_pc];
            r_state <= S_ISSUE;
          end
          S_ISSUE: begin
            if (!w_is_send) begin
              r_valid <= 1'b1;
              r_cnt   <= '0;
              r_state <= (GAP == 0) ? S_POST : S_GAP;
            end else if (!bus.i_tx_busy) begin
              r_valid <= 1'b1;
              r_cnt   <= '0;
              r_seen  <= 1'b0;
              r_state <= S_TXWAIT;
            end
          end
          S_GAP: begin
            if (r_cnt == CNT_W'(GAP - 1)) r_state <= S_POST;
            else                          r_cnt   <= r_cnt + 1'b1;
          end
          // Leave on busy high-then-low; the guard only covers a UART that never reacts.
          S_TXWAIT: begin
            if (bus.i_tx_busy)                  r_seen  <= 1'b1;
            else if (r_seen)                    r_state <= S_POST;
            else if (r_cnt == CNT_W'(GUARD - 1)) r_state <= S_POST;
            else                                r_cnt   <= r_cnt + 1'b1;
          end
`ifdef SEQ_PROG_STEP_EN
          S_STEP: begin
            if (w_step_rise) r_state <= S_NEXT;
          end
`endif
          S_NEXT: begin
            if (w_last) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_pc    <= r_pc + 1'b1;
              r_state <= S_FETCH;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  logic w_unused;
  assign w_unused = w_step_rise;

  assign bus.o_inst       = r_inst;
  assign bus.o_inst_valid = r_valid;
  assign bus.o_pc         = r_pc;
  assign bus.o_busy       = r_busy;
  assign bus.o_done       = r_done;
endmodule

// File: tb/tb_seq_prog_ctrl.sv
// Bench for seq_prog_ctrl: directed scenarios plus random programs against a program-order model
// with a reactive UART busy model.
module tb_seq_prog_ctrl;
  localparam int INST_W   = 8;
  localparam int DEPTH_LG = 4;
  localparam int DEPTH    = 16;
  localparam int GAP      = 1;
  localparam int GUARD    = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_prog_ctrl_if #(.INST_W(INST_W), .DEPTH_LG(DEPTH_LG)) bus ();

`ifdef SEQ_PROG_STEP_EN
  logic step_man = 1'b0;
  logic step_auto = 1'b0;
  logic step_tog = 1'b0;
  always @(negedge clk) step_tog <= ~step_tog;
  logic i_step;
  assign i_step = step_auto ? step_tog : step_man;
`endif

  seq_prog_ctrl #(.INST_W(INST_W), .DEPTH_LG(DEPTH_LG), .GAP(GAP), .GUARD(GUARD)) dut (
    .clk (clk),
    .rst (rst),
`ifdef SEQ_PROG_STEP_EN
    .i_step (i_step),
`endif
    .bus (bus.slave)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  logic man_busy = 1'b0;
  logic uart_auto = 1'b0;
  int   busy_left = 0;
  assign bus.i_tx_busy = uart_auto ? (busy_left > 0) : man_busy;

  typedef struct {
    logic [7:0] inst;
    int cyc;
    int h;
    int prev_busy;
  } strobe_t;
  strobe_t strobes[$];
  int last_busy_cyc = -100;

  logic [7:0] mram [DEPTH];

  function automatic bit is_send(input logic [7:0] i);
    return i[7:6] == 2'b11;
  endfunction

  // Monitor and UART model: a SEND strobe makes the UART busy for h cycles (h=0: never busy).
  always @(negedge clk) begin
    strobe_t s;
    if (uart_auto && busy_left > 0) busy_left = busy_left - 1;
    if (bus.o_inst_valid === 1'b1) begin
      s.inst = bus.o_inst;
      s.cyc = cyc;
      s.prev_busy = last_busy_cyc;
      s.h = 0;
      if (uart_auto && is_send(bus.o_inst)) begin
        s.h = int'($urandom_range(0, 4));
        busy_left = s.h;
      end
      strobes.push_back(s);
    end
    if (uart_auto ? (busy_left > 0) : man_busy) last_busy_cyc = cyc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input logic [7:0] d);
    bus.i_load_we   = 1'b1;
    bus.i_load_addr = 4'(a);
    bus.i_load_data = d;
    tick();
    bus.i_load_we = 1'b0;
    mram[a] = d;
  endtask

  task automatic run_prog(input int len, input bit wr_during);
    int n0, start_cyc, to, done_cyc;
    strobe_t p, c;
    n0 = strobes.size();
    bus.i_len = 5'(len);
    bus.i_start = 1'b1;
    start_cyc = cyc;
    tick();
    bus.i_start = 1'b0;
    to = 0;
    while (bus.o_done !== 1'b1 && to < 2000) begin
      if (wr_during) begin
        bus.i_load_we   = 1'b1;
        bus.i_load_addr = 4'($urandom);
        bus.i_load_data = 8'($urandom);
      end
      tick();
      to++;
    end
    bus.i_load_we = 1'b0;
    done_cyc = cyc;
    chk("run_timeout", 32'(to < 2000), 32'd1);
    chk("strobe_count", 32'(strobes.size() - n0), 32'(len));
    chk("pc_end", 32'(bus.o_pc), (len == 0) ? 32'd0 : 32'(len - 1));
    chk("done_busy", {30'd0, bus.o_done, bus.o_busy}, 32'b10);
    if (len == 0) chk("len0_latency", 32'(to), 32'd0);
    for (int k = 0; k < len && n0 + k < strobes.size(); k++) begin
      c = strobes[n0 + k];
      chk($sformatf("inst_%0d", k), 32'(c.inst), 32'(mram[k]));
`ifndef SEQ_PROG_STEP_EN
      if (k == 0) chk("first_latency", 32'(c.cyc - start_cyc), 32'd3);
      else begin
        p = strobes[n0 + k - 1];
        if (!is_send(p.inst))
          chk($sformatf("gap_%0d", k), 32'(c.cyc - p.cyc), 32'(3 + GAP));
        else if (p.h == 0)
          chk($sformatf("guard_%0d", k), 32'(c.cyc - p.cyc), 32'(3 + GUARD));
        else begin
          chk($sformatf("busy_rose_%0d", k), 32'(c.prev_busy >= p.cyc), 32'd1);
          chk($sformatf("busy_fell_%0d", k), 32'(c.cyc > c.prev_busy), 32'd1);
        end
      end
      if (k == len - 1) begin
        if (!is_send(c.inst)) chk("done_after_gap", 32'(done_cyc - c.cyc), 32'(GAP + 1));
        else if (c.h == 0)    chk("done_after_guard", 32'(done_cyc - c.cyc), 32'(GUARD + 1));
      end
`endif
    end
  endtask

  initial begin
    int n0, to, drop_cyc, len;
    bus.i_load_we = 1'b0;
    bus.i_load_addr = '0;
    bus.i_load_data = '0;
    bus.i_len = '0;
    bus.i_start = 1'b0;
    bus.i_abort = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_pc", 32'(bus.o_pc), 32'd0);
    chk("rst_valid", 32'(bus.o_inst_valid), 32'd0);
    chk("rst_busy", 32'(bus.o_busy), 32'd0);
    chk("rst_done", 32'(bus.o_done), 32'd0);
    chk("rst_inst", 32'(bus.o_inst), 32'd0);
    rst = 1'b0;
    tick();
`ifdef SEQ_PROG_STEP_EN
    step_auto = 1'b1;
`endif

    // Single push
    load(0, 8'h05);
    run_prog(1, 1'b0);
    chk("t1_inst", 32'(bus.o_inst), 32'h05);

    // push r0,3; push r1,4; add r0,r1->r2; send r2 with UART never busy
    load(0, 8'h03); load(1, 8'h14); load(2, 8'h46); load(3, 8'hE0);
    run_prog(4, 1'b0);

    // SEND, then a push: guard timeout path lets the program continue
    load(0, 8'hE0); load(1, 8'h05);
    run_prog(2, 1'b0);

`ifndef SEQ_PROG_STEP_EN
    // SEND stalled by busy, then must see busy rise and fall before the next issue
    n0 = strobes.size();
    man_busy = 1'b1;
    bus.i_len = 5'd2;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    repeat (10) tick();
    chk("t3_no_strobe", 32'(strobes.size() - n0), 32'd0);
    man_busy = 1'b0;
    drop_cyc = cyc;
    to = 0;
    while (bus.o_inst_valid !== 1'b1 && to < 10) begin tick(); to++; end
    chk("t3_strobe_seen", 32'(to < 10), 32'd1);
    man_busy = 1'b1;
    repeat (8) tick();
    chk("t3_strobe_at", (strobes.size() > n0) ? 32'(strobes[n0].cyc - drop_cyc) : 32'hFFFF, 32'd1);
    chk("t3_one_strobe", 32'(strobes.size() - n0), 32'd1);
    chk("t3_still_busy", 32'(bus.o_busy), 32'd1);
    man_busy = 1'b0;
    to = 0;
    while (bus.o_done !== 1'b1 && to < 30) begin tick(); to++; end
    chk("t3_done", 32'(bus.o_done), 32'd1);
    chk("t3_two_strobes", 32'(strobes.size() - n0), 32'd2);
`endif

    // Empty program
    run_prog(0, 1'b0);

    // Full-depth random program, rerun with ignored writes mid-run, then rerun clean
    uart_auto = 1'b1;
    for (int a = 0; a < DEPTH; a++) load(a, 8'($urandom));
    run_prog(16, 1'b0);
    run_prog(16, 1'b1);
    run_prog(16, 1'b0);

    // Random programs of random length
    for (int r = 0; r < 6; r++) begin
      len = int'($urandom_range(1, 16));
      for (int a = 0; a < len; a++) load(a, 8'($urandom));
      run_prog(len, 1'b0);
    end
    uart_auto = 1'b0;

    // Abort during GAP together with start
    for (int a = 0; a < 4; a++) load(a, 8'(a + 1));
    n0 = strobes.size();
    bus.i_len = 5'd4;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    to = 0;
    while (bus.o_inst_valid !== 1'b1 && to < 10) begin tick(); to++; end
    bus.i_abort = 1'b1;
    bus.i_start = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    bus.i_start = 1'b0;
    chk("ab_pc", 32'(bus.o_pc), 32'd0);
    chk("ab_valid", 32'(bus.o_inst_valid), 32'd0);
    chk("ab_busy", 32'(bus.o_busy), 32'd0);
    chk("ab_done", 32'(bus.o_done), 32'd0);
    repeat (20) tick();
    chk("ab_no_more", 32'(strobes.size() - n0), 32'd1);

    // Abort beats a same-cycle start from IDLE
    bus.i_abort = 1'b1;
    bus.i_start = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    bus.i_start = 1'b0;
    chk("ab_idle_busy", 32'(bus.o_busy), 32'd0);

    // Reset in the ISSUE cycle
    n0 = strobes.size();
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("rr_pc", 32'(bus.o_pc), 32'd0);
    chk("rr_valid", 32'(bus.o_inst_valid), 32'd0);
    chk("rr_busy", 32'(bus.o_busy), 32'd0);
    chk("rr_done", 32'(bus.o_done), 32'd0);
    chk("rr_inst", 32'(bus.o_inst), 32'd0);
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("rr_no_strobe", 32'(strobes.size() - n0), 32'd0);

`ifdef SEQ_PROG_STEP_EN
    // One instruction per i_step rising edge; a held-high step advances only once
    step_auto = 1'b0;
    step_man = 1'b0;
    tick();
    load(0, 8'h01); load(1, 8'h02);
    n0 = strobes.size();
    bus.i_len = 5'd2;
    bus.i_start = 1'b1;
    tick();
    bus.i_start = 1'b0;
    repeat (12) tick();
    chk("st_first", 32'(strobes.size() - n0), 32'd1);
    step_man = 1'b1;
    repeat (12) tick();
    chk("st_second", 32'(strobes.size() - n0), 32'd2);
    chk("st_wait", 32'(bus.o_done), 32'd0);
    step_man = 1'b0;
    tick();
    step_man = 1'b1;
    tick();
    step_man = 1'b0;
    repeat (3) tick();
    chk("st_done", 32'(bus.o_done), 32'd1);
    chk("st_count", 32'(strobes.size() - n0), 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
